// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmitter.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } ps2_state_e;

    // Odd parity: the returned bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_transmitter_if.sv
// Host-side request/status bundle of the PS/2 transmitter.
interface ps2_transmitter_if;
    // A request is taken on a clk_sys edge where tx_vld && tx_rdy; tx_data is captured
    // on that edge, tx_rdy drops from the next cycle and tx_vld is ignored until it rises.
    logic       tx_vld;
    logic [7:0] tx_data;
    logic       tx_rdy;
    logic       tx_active;
    logic       tx_done;
    logic       tx_err;

    modport slave (
        input  tx_vld, tx_data,
        output tx_rdy, tx_active, tx_done, tx_err
    );

    modport master (
        output tx_vld, tx_data,
        input  tx_rdy, tx_active, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser followed by a glitch filter for one open-drain PS/2 pad.
module ps2_line_sync #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic line_i,
    output logic filt_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          meta_q, sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The filtered level flips only after FILT_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one byte with odd parity
// and checks the device acknowledge, with an overall transaction timeout.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 6000,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int FILT_LEN    = 8
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    ps2_transmitter_if.slave   host,
    input  logic               ps2_clk_in,
    input  logic               ps2_data_in,
    output logic               ps2_clk_oe,
    output logic               ps2_data_oe,
    output ps2_state_e         state_o
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int BIT_W = $clog2(PS2_FRAME_BITS + 1);

    ps2_state_e       state_q, state_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             data_oe_q, data_oe_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_prev_q;
    logic             clk_filt, data_filt, clk_fall;

    ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_clk_sync (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .line_i  (ps2_clk_in),
        .filt_o  (clk_filt)
    );

    ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_data_sync (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .line_i  (ps2_data_in),
        .filt_o  (data_filt)
    );

    assign clk_fall = clk_prev_q & ~clk_filt;

    always_comb begin
        state_d   = state_q;
        inh_d     = inh_q;
        to_d      = to_q;
        bit_d     = bit_q;
        data_d    = data_q;
        data_oe_d = data_oe_q;
        ack_d     = ack_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                inh_d     = '0;
                to_d      = '0;
                bit_d     = '0;
                if (host.tx_vld) begin
                    data_d  = host.tx_data;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_q == INH_W'(INHIBIT_CYC - 1)) begin
                    state_d   = ST_START;
                    data_oe_d = 1'b1;
                    to_d      = '0;
                end else begin
                    inh_d = inh_q + INH_W'(1);
                end
            end
            default: begin
                // Every state from START onward shares one timeout budget.
                to_d = to_q + TO_W'(1);
                if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = ST_IDLE;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    case (state_q)
                        ST_START: if (clk_fall) begin
                            data_oe_d = ~data_q[0];
                            bit_d     = BIT_W'(1);
                            state_d   = ST_DATA;
                        end
                        ST_DATA: if (clk_fall) begin
                            bit_d = bit_q + BIT_W'(1);
                            if (bit_q == BIT_W'(8)) begin
                                data_oe_d = ~odd_parity(data_q);
                                state_d   = ST_PARITY;
                            end else begin
                                data_oe_d = ~data_q[bit_q[2:0]];
                            end
                        end
                        ST_PARITY: if (clk_fall) begin
                            data_oe_d = 1'b0;
                            bit_d     = bit_q + BIT_W'(1);
                            state_d   = ST_STOP;
                        end
                        ST_STOP: if (clk_fall) begin
                            ack_d   = data_filt;
                            bit_d   = bit_q + BIT_W'(1);
                            state_d = ST_ACK;
                        end
                        ST_ACK: begin
                            if (ack_q) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_WAIT_IDLE;
                            end
                        end
                        ST_WAIT_IDLE: if (clk_filt && data_filt) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            inh_q      <= '0;
            to_q       <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            data_oe_q  <= 1'b0;
            ack_q      <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            inh_q      <= inh_d;
            to_q       <= to_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            data_oe_q  <= data_oe_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            clk_prev_q <= clk_filt;
        end
    end

    assign ps2_clk_oe     = (state_q == ST_INHIBIT);
    assign ps2_data_oe    = data_oe_q;
    assign host.tx_rdy    = (state_q == ST_IDLE);
    assign host.tx_active = (state_q != ST_IDLE);
    assign host.tx_done   = done_q;
    assign host.tx_err    = err_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with an open-drain PS/2 device model and frame scoreboard.
module tb_ps2_transmitter;
    import ps2_pkg::*;

    localparam int INH      = 6000;
    localparam int TO       = 10000;
    localparam int FILT     = 8;
    localparam int LOW_CYC  = 20;
    localparam int HIGH_CYC = 20;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       rst_n = 1'b0;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    ps2_state_e state_dbg;

    ps2_transmitter_if host();

    // Wired-AND bus with pull-ups.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_transmitter #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO),
        .FILT_LEN    (FILT)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .host        (host),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .state_o     (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int inh_run = 0, last_inh = 0, start_cyc = 0, err_cyc = 0;
    ps2_state_e prev_state = ST_IDLE;

    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (host.tx_done) done_cnt = done_cnt + 1;
        if (host.tx_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (host.tx_done && host.tx_err) both_cnt = both_cnt + 1;
        if (ps2_clk_oe) begin
            inh_run = inh_run + 1;
        end else begin
            if (inh_run != 0) last_inh = inh_run;
            inh_run = 0;
        end
        if (state_dbg == ST_START && prev_state != ST_START) start_cyc = cyc;
        prev_state = state_dbg;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame as the device sees it, bit 0 first: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] make_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, logic'(ones % 2 == 0), d, 1'b0};
    endfunction

    task automatic request(input logic [7:0] d, input bit push);
        int n = 0;
        while (!host.tx_rdy && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        host.tx_vld  = 1'b1;
        host.tx_data = d;
        if (push) exp_q.push_back(make_frame(d));
        @(negedge clk_sys);
        host.tx_vld = 1'b0;
        check("rdy_drop", 32'(host.tx_rdy), 0);
        check("active_rise", 32'(host.tx_active), 1);
    endtask

    task automatic device(input bit ack, input int nclk);
        logic [10:0] got = '0;
        logic [10:0] exp;
        int n = 0;
        while (!(ps2_data_in == 1'b0 && ps2_clk_in == 1'b1) && n < INH + 1000) begin
            @(negedge clk_sys);
            n++;
        end
        check("rts_seen", 32'(ps2_data_in == 1'b0 && ps2_clk_in == 1'b1), 1);
        if (ps2_data_in == 1'b0 && ps2_clk_in == 1'b1) begin
            repeat (30) @(negedge clk_sys);
            got[0] = ps2_data_in;
            for (int p = 1; p <= nclk; p++) begin
                if (p == 11 && ack) begin
                    dev_data_low = 1'b1;
                    repeat (5) @(negedge clk_sys);
                end
                dev_clk_low = 1'b1;
                repeat (LOW_CYC) @(negedge clk_sys);
                if (p <= 10) got[p] = ps2_data_in;
                dev_clk_low = 1'b0;
                repeat (HIGH_CYC) @(negedge clk_sys);
                if (p == 11) dev_data_low = 1'b0;
            end
            if (nclk == 11) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check("frame", 32'(got), 32'(exp));
                end
            end
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!host.tx_rdy && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, 32'(host.tx_rdy), 1);
        repeat (2) @(negedge clk_sys);
    endtask

    int d0, e0;

    initial begin
        host.tx_vld  = 1'b0;
        host.tx_data = 8'h00;
        rst_n = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("rst_rdy", 32'(host.tx_rdy), 1);
        check("rst_active", 32'(host.tx_active), 0);
        check("rst_done", 32'(host.tx_done), 0);
        check("rst_err", 32'(host.tx_err), 0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("post_rst_rdy", 32'(host.tx_rdy), 1);

        // 0xF4 acknowledged
        d0 = done_cnt; e0 = err_cnt;
        fork
            request(8'hF4, 1'b1);
            device(1'b1, 11);
        join
        wait_ready("f4_ready", 500);
        check("f4_done", 32'(done_cnt - d0), 1);
        check("f4_err", 32'(err_cnt - e0), 0);
        check("f4_clk_oe", 32'(ps2_clk_oe), 0);
        check("f4_data_oe", 32'(ps2_data_oe), 0);
        check("f4_inhibit_len", 32'(last_inh), INH);

        // 0xFF: parity bit 1, exact inhibit length
        d0 = done_cnt; e0 = err_cnt;
        fork
            request(8'hFF, 1'b1);
            device(1'b1, 11);
        join
        wait_ready("ff_ready", 500);
        check("ff_done", 32'(done_cnt - d0), 1);
        check("ff_err", 32'(err_cnt - e0), 0);
        check("ff_inhibit_len", 32'(last_inh), INH);

        // No acknowledge from the device
        d0 = done_cnt; e0 = err_cnt;
        fork
            request(8'h5A, 1'b1);
            device(1'b0, 11);
        join
        wait_ready("nack_ready", 500);
        check("nack_err", 32'(err_cnt - e0), 1);
        check("nack_done", 32'(done_cnt - d0), 0);
        check("nack_clk_oe", 32'(ps2_clk_oe), 0);
        check("nack_data_oe", 32'(ps2_data_oe), 0);

        // Device never clocks
        d0 = done_cnt; e0 = err_cnt;
        request(8'h3C, 1'b0);
        wait_ready("to_ready", INH + TO + 200);
        check("to_err", 32'(err_cnt - e0), 1);
        check("to_done", 32'(done_cnt - d0), 0);
        check("to_latency", 32'(err_cyc - start_cyc), TO);
        check("to_clk_oe", 32'(ps2_clk_oe), 0);
        check("to_data_oe", 32'(ps2_data_oe), 0);

        // Reset pulse while data bit 4 of 0x6C (a 0) is on the bus
        d0 = done_cnt; e0 = err_cnt;
        fork
            request(8'h6C, 1'b0);
            device(1'b1, 5);
        join
        check("abort_in_data", 32'(state_dbg == ST_DATA), 1);
        check("abort_bit4_drive", 32'(ps2_data_oe), 1);
        rst_n = 1'b0;
        @(negedge clk_sys);
        check("abort_data_oe", 32'(ps2_data_oe), 0);
        check("abort_clk_oe", 32'(ps2_clk_oe), 0);
        check("abort_rdy", 32'(host.tx_rdy), 1);
        check("abort_active", 32'(host.tx_active), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        check("abort_no_err", 32'(err_cnt - e0), 0);

        // A second request while busy is dropped
        d0 = done_cnt; e0 = err_cnt;
        fork
            request(8'hF4, 1'b1);
            device(1'b1, 11);
            begin
                repeat (INH + 100) @(negedge clk_sys);
                host.tx_vld  = 1'b1;
                host.tx_data = 8'hAA;
                repeat (3) @(negedge clk_sys);
                check("busy_rdy", 32'(host.tx_rdy), 0);
                repeat (50) @(negedge clk_sys);
                host.tx_vld = 1'b0;
            end
        join
        wait_ready("busy_ready", 500);
        check("busy_done", 32'(done_cnt - d0), 1);
        check("busy_err", 32'(err_cnt - e0), 0);
        repeat (20) @(negedge clk_sys);
        check("busy_no_queue", 32'(host.tx_active), 0);
        check("sb_drained", 32'(exp_q.size()), 0);
        check("done_err_exclusive", 32'(both_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_transmitter.md
PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 6000, meaning clk_sys cycles the PS2 clock is held low before the request (120 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_000_000, meaning the maximum clk_sys cycles from START entry to transaction end (20 ms).
REQ-003 SHALL have parameter FILT_LEN, default 8, meaning the consecutive equal samples needed to change a filtered line.
REQ-004 clk_sys  input  1  system clock; one clock domain only.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 tx_vld  input  1  request to send tx_data.
REQ-007 tx_data  input  8  host-to-device command byte.
REQ-008 tx_rdy  output  1  idle, can accept a request.
REQ-009 tx_active  output  1  transaction in progress; the receiver ignores the lines while high.
REQ-010 tx_done  output  1  one-cycle pulse: byte acknowledged by the device.
REQ-011 tx_err  output  1  one-cycle pulse: no acknowledge, or timeout.
REQ-012 ps2_clk_in, ps2_data_in  input  1 each  raw pad levels, asynchronous.
REQ-013 ps2_clk_oe, ps2_data_oe  output  1 each  1 = drive pad low, 0 = release (open-drain).

Function
REQ-014 SHALL pass each pad input through a 2-flop synchroniser and a FILT_LEN-sample filter; a falling edge (fall) is a filtered 1->0 transition.
REQ-015 SHALL accept a request only when tx_vld && tx_rdy, capture tx_data that cycle, and deassert tx_rdy from the next cycle.
REQ-016 SHALL ignore tx_vld while busy; there is no queueing.
REQ-017 SHALL implement states IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-018 IDLE: both oe = 0, tx_rdy = 1; on accept -> INHIBIT.
REQ-019 INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYC cycles, then -> START.
REQ-020 START: ps2_data_oe = 1 and ps2_clk_oe = 0; on fall -> DATA with bit index 0.
REQ-021 DATA: on each fall, set ps2_data_oe = ~tx_data[idx], LSB first, and increment idx; the fall after bit 7 is driven -> PARITY.
REQ-022 PARITY: drive the odd parity bit (~^tx_data) at the current fall; the next fall -> STOP.
REQ-023 STOP: ps2_data_oe = 0 (stop bit = 1); the next fall -> ACK.
REQ-024 ACK: sample the filtered data line at the 11th fall; 0 -> WAIT_IDLE; 1 -> tx_err and IDLE.
REQ-025 WAIT_IDLE: wait until both filtered lines are high, then pulse tx_done and -> IDLE.
REQ-026 SHALL start a timeout counter on START entry; on reaching TIMEOUT_CYC in any state from START to WAIT_IDLE, release both oe, pulse tx_err, and -> IDLE.
REQ-027 tx_active SHALL be 1 in every non-IDLE state.
REQ-028 tx_done and tx_err SHALL never assert in the same cycle.
REQ-029 A fall in IDLE or INHIBIT SHALL be ignored.

Reset
REQ-030 While rst_n = 0 at a clk_sys edge: state = IDLE; tx_rdy = 1; tx_active, tx_done, tx_err, ps2_clk_oe, ps2_data_oe = 0; counters = 0; filters = 1.
REQ-031 Reset asserted mid-transaction SHALL release both lines at the next clk_sys edge, with no tx_done or tx_err pulse.

Structure
REQ-032 The state enum, PS2_FRAME_BITS = 11 and the odd-parity function SHALL live in the shared package ps2_pkg.
REQ-033 The synchroniser and filter SHALL be one sub-module, ps2_line_sync, instantiated once per line.
REQ-034 The FSM, bit counter, inhibit counter and timeout counter SHALL sit in ps2_transmitter.

Verification
REQ-035 Send 0xF4 with a device model that acknowledges -> data bits 0,0,1,0,1,1,1,1, parity 0, stop 1, one tx_done.
REQ-036 Send 0xFF -> parity 1, tx_done; ps2_clk_oe high for exactly 6000 cycles beforehand.
REQ-037 Device leaves data high at the ack bit -> one tx_err, no tx_done, both oe = 0.
REQ-038 Device never clocks -> tx_err exactly 1_000_000 cycles after START entry; lines released.
REQ-039 Pulse rst_n low during data bit 4 -> both oe = 0 and tx_rdy = 1 the next cycle; no pulses.
REQ-040 tx_vld = 1 with 0xAA during a 0xF4 transfer -> 0xAA is ignored and the 0xF4 frame is intact.
